// File: rtl/calc_sm_acc_if.sv
// rtl/calc_sm_acc_if.sv - operand/result stream bundle for calc_sm_acc
//
// Purpose: groups the sink (operand) and source (result) handshake signals.
//   slave  : the calculator's view (consumes operands, produces results)
//   master : the surrounding datapath's view (drives operands, accepts results)
// Signals:
//   MODE          per-beat op: 00 A-B, 01 A+B, 10 ACC+A, 11 ACC-A
//   SINK_VALID    operand beat valid
//   SINK_READY    calculator can accept an operand beat
//   SINK_DATAA    operand A (sign-magnitude)
//   SINK_DATAB    operand B (sign-magnitude, unused in modes 1x)
//   SINK_CLR      accumulate modes: start from 0 instead of ACC
//   SOURCE_VALID  result valid
//   SOURCE_READY  downstream accepts result
//   SOURCE_DATA   result (sign-magnitude)
//   SOURCE_OVF    result magnitude overflowed
interface calc_sm_acc_if #(
   parameter int WIDTH = 16
);
   logic [1:0]       MODE;
   logic             SINK_VALID;
   logic             SINK_READY;
   logic [WIDTH-1:0] SINK_DATAA;
   logic [WIDTH-1:0] SINK_DATAB;
   logic             SINK_CLR;
   logic             SOURCE_VALID;
   logic             SOURCE_READY;
   logic [WIDTH-1:0] SOURCE_DATA;
   logic             SOURCE_OVF;

   modport slave (
      input  MODE, SINK_VALID, SINK_DATAA, SINK_DATAB, SINK_CLR, SOURCE_READY,
      output SINK_READY, SOURCE_VALID, SOURCE_DATA, SOURCE_OVF
   );

   modport master (
      output MODE, SINK_VALID, SINK_DATAA, SINK_DATAB, SINK_CLR, SOURCE_READY,
      input  SINK_READY, SOURCE_VALID, SOURCE_DATA, SOURCE_OVF
   );
endinterface

// File: rtl/calc_sm_acc.sv
// rtl/calc_sm_acc.sv - 2-stage sign-magnitude add/sub/accumulate unit
//
// Purpose: WIDTH-bit sign-magnitude calculator (MSB sign, rest magnitude)
//   with valid/ready handshake on both sides, a 2-stage pipeline, an
//   accumulator with per-beat clear, and an overflow flag.
// Ports:
//   CLK      clock
//   RESET_n  asynchronous active-low reset, discards in-flight beats
//   bus      calc_sm_acc_if.slave (operand sink / result source)
// Configuration:
//   CALC_SAT_EN  defined: overflowing magnitudes clamp to all-ones
//                undefined: overflowing magnitudes wrap to WIDTH-1 bits
module calc_sm_acc #(
   parameter int WIDTH = 16
) (
   input  logic         CLK,
   input  logic         RESET_n,
   calc_sm_acc_if.slave bus
);
   localparam int MW = WIDTH - 1;   // magnitude width

   logic             en;

   // stage 1: captured beat
   logic             s1_valid;
   logic [1:0]       s1_mode;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_clr;

   // stage 2: output registers and accumulator
   logic             src_valid;
   logic [WIDTH-1:0] src_data;
   logic             src_ovf;
   logic [WIDTH-1:0] acc;

   // combinational datapath between the stages
   logic             sub;
   logic [WIDTH-1:0] op_x;
   logic [WIDTH-1:0] op_y;
   logic [MW-1:0]    x_mag;
   logic [MW-1:0]    y_mag;
   logic             x_neg;
   logic             y_neg;
   logic [WIDTH-1:0] sum;
   logic [MW-1:0]    res_mag;
   logic             res_neg;
   logic             res_ovf;
   logic [WIDTH-1:0] res_data;

   // Whole pipeline moves together; a full output register with a stalled
   // sink freezes both stages, so at most two beats are held.
   assign en             = !src_valid | bus.SOURCE_READY;
   assign bus.SINK_READY = en;

   assign bus.SOURCE_VALID = src_valid;
   assign bus.SOURCE_DATA  = src_data;
   assign bus.SOURCE_OVF   = src_ovf;

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         s1_valid <= 1'b0;
         s1_mode  <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_clr   <= 1'b0;
      end else if (en) begin
         // en doubles as SINK_READY, so SINK_VALID alone marks acceptance
         s1_valid <= bus.SINK_VALID;
         s1_mode  <= bus.MODE;
         s1_a     <= bus.SINK_DATAA;
         s1_b     <= bus.SINK_DATAB;
         s1_clr   <= bus.SINK_CLR;
      end
   end

   always_comb begin
      sub     = (s1_mode == 2'b00) || (s1_mode == 2'b11);
      op_x    = s1_mode[1] ? (s1_clr ? '0 : acc) : s1_a;
      op_y    = s1_mode[1] ? s1_a : s1_b;
      x_mag   = op_x[MW-1:0];
      y_mag   = op_y[MW-1:0];
      // a zero magnitude counts as positive whatever its sign bit says
      x_neg   = op_x[MW] & (x_mag != '0);
      y_neg   = (op_y[MW] ^ sub) & (y_mag != '0);
      sum     = {1'b0, x_mag} + {1'b0, y_mag};
      res_neg = 1'b0;
      res_mag = '0;
      res_ovf = 1'b0;
      if (x_neg == y_neg) begin
         res_neg = x_neg;
         res_ovf = sum[MW];
         res_mag = sum[MW-1:0];
`ifdef CALC_SAT_EN
         if (sum[MW]) begin
            res_mag = '1;
         end
`endif
      end else if (x_mag >= y_mag) begin
         res_neg = x_neg;
         res_mag = x_mag - y_mag;
      end else begin
         res_neg = y_neg;
         res_mag = y_mag - x_mag;
      end
      // never emit negative zero (covers equal-magnitude cancel and wrap to 0)
      res_data = {res_neg & (res_mag != '0), res_mag};
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         src_valid <= 1'b0;
         src_data  <= '0;
         src_ovf   <= 1'b0;
      end else if (en) begin
         src_valid <= s1_valid;
         src_data  <= res_data;
         src_ovf   <= res_ovf;
      end
   end

   // ACC is written on the same edge the beat leaves stage 1, so the next
   // beat (already in stage 1 after that edge) sees the fresh value.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         acc <= '0;
      end else if (en && s1_valid && s1_mode[1]) begin
         acc <= res_data;
      end
   end
endmodule

// File: tb/tb_calc_sm_acc.sv
// tb/tb_calc_sm_acc.sv - self-checking bench for calc_sm_acc
module tb_calc_sm_acc;
   localparam int W = 16;

   logic CLK;
   logic RESET_n;
   int   n_checks;
   int   n_errors;
   longint acc_m;
   logic [W:0] exp_q[$];
   logic [W:0] got_q[$];

   calc_sm_acc_if #(.WIDTH(W)) bus_if();

   calc_sm_acc #(.WIDTH(W)) dut (
      .CLK     (CLK),
      .RESET_n (RESET_n),
      .bus     (bus_if)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic longint smval(input logic [W-1:0] v);
      longint m;
      m = longint'(v[W-2:0]);
      return v[W-1] ? -m : m;
   endfunction

   // reference: signed integer arithmetic, then re-encode as sign-magnitude
   task automatic model(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, output logic [W:0] e);
      longint x, y, s, mag, maxm;
      logic   ovf, neg;
      maxm = (longint'(1) << (W-1)) - 1;
      x    = m[1] ? (c ? 0 : acc_m) : smval(a);
      y    = m[1] ? smval(a) : smval(b);
      s    = (m == 2'b00 || m == 2'b11) ? x - y : x + y;
      mag  = (s < 0) ? -s : s;
      ovf  = (mag > maxm);
      if (ovf) begin
`ifdef CALC_SAT_EN
         mag = maxm;
`else
         mag = mag % (maxm + 1);
`endif
      end
      neg = (s < 0) && (mag != 0);
      e   = {ovf, neg, mag[W-2:0]};
      if (m[1]) acc_m = neg ? -mag : mag;
   endtask

   // drive one cycle's inputs at negedge, then observe what the next edge will do
   task automatic cycle(input logic v, input logic [1:0] m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c, input logic rdy);
      logic [W:0] e;
      @(negedge CLK);
      bus_if.SINK_VALID   = v;
      bus_if.MODE         = m;
      bus_if.SINK_DATAA   = a;
      bus_if.SINK_DATAB   = b;
      bus_if.SINK_CLR     = c;
      bus_if.SOURCE_READY = rdy;
      #1;
      if (bus_if.SOURCE_VALID && bus_if.SOURCE_READY) begin
         got_q.push_back({bus_if.SOURCE_OVF, bus_if.SOURCE_DATA});
         if (exp_q.size() == 0) begin
            check("spurious_out", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", {16'd0, bus_if.SOURCE_DATA}, {16'd0, e[W-1:0]});
            check("sb_ovf", {31'd0, bus_if.SOURCE_OVF}, {31'd0, e[W]});
         end
      end
      if (bus_if.SINK_VALID && bus_if.SINK_READY && RESET_n) begin
         model(m, a, b, c, e);
         exp_q.push_back(e);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
      check("drain_empty", exp_q.size(), 32'd0);
   endtask

   task automatic expect_out(input string tag, input logic [W:0] exp);
      if (got_q.size() == 0) begin
         check(tag, 32'hDEAD, {15'd0, exp});
      end else begin
         check(tag, {15'd0, got_q.pop_front()}, {15'd0, exp});
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      acc_m    = 0;
      RESET_n  = 1'b0;
      bus_if.SINK_VALID   = 1'b0;
      bus_if.MODE         = 2'b00;
      bus_if.SINK_DATAA   = '0;
      bus_if.SINK_DATAB   = '0;
      bus_if.SINK_CLR     = 1'b0;
      bus_if.SOURCE_READY = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      check("rst_valid", {31'd0, bus_if.SOURCE_VALID}, 32'd0);
      check("rst_data", {16'd0, bus_if.SOURCE_DATA}, 32'd0);
      check("rst_ovf", {31'd0, bus_if.SOURCE_OVF}, 32'd0);
      check("rst_ready", {31'd0, bus_if.SINK_READY}, 32'd1);
      @(negedge CLK);
      RESET_n = 1'b1;

      // latency: accept, one empty observation, then valid
      got_q.delete();
      cycle(1'b1, 2'b01, 16'h0001, 16'h8002, 1'b0, 1'b1);
      cycle(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
      check("lat_edge1", {31'd0, bus_if.SOURCE_VALID}, 32'd0);
      cycle(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
      check("lat_edge2", {31'd0, bus_if.SOURCE_VALID}, 32'd1);
      drain();
      expect_out("t1_add", 17'h08001);

      got_q.delete();
      cycle(1'b1, 2'b00, 16'h8002, 16'h8005, 1'b0, 1'b1);
      cycle(1'b1, 2'b00, 16'h0005, 16'h0002, 1'b0, 1'b1);
      cycle(1'b1, 2'b00, 16'h0001, 16'h8002, 1'b0, 1'b1);
      cycle(1'b1, 2'b01, 16'h0002, 16'h8002, 1'b0, 1'b1);
      cycle(1'b1, 2'b00, 16'h8000, 16'h0000, 1'b0, 1'b1);
      cycle(1'b1, 2'b01, 16'hFFFF, 16'h8001, 1'b0, 1'b1);
      cycle(1'b1, 2'b01, 16'h3FFF, 16'h3FFF, 1'b0, 1'b1);
      drain();
      expect_out("t2_sub_a", 17'h00003);
      expect_out("t2_sub_b", 17'h00003);
      expect_out("t2_sub_c", 17'h00003);
      expect_out("t3_zero_a", 17'h00000);
      expect_out("t3_zero_b", 17'h00000);
`ifdef CALC_SAT_EN
      expect_out("t4_ovf", 17'h1FFFF);
`else
      expect_out("t4_ovf", 17'h10000);
`endif
      expect_out("t4_noovf", 17'h07FFE);

      // accumulate back-to-back; the mode-01 beat must not disturb ACC (-2)
      got_q.delete();
      cycle(1'b1, 2'b10, 16'h0005, 16'h0000, 1'b1, 1'b1);
      cycle(1'b1, 2'b10, 16'h0003, 16'h0000, 1'b0, 1'b1);
      cycle(1'b1, 2'b11, 16'h000A, 16'h0000, 1'b0, 1'b1);
      cycle(1'b1, 2'b01, 16'h0001, 16'h0001, 1'b0, 1'b1);
      cycle(1'b1, 2'b10, 16'h8002, 16'h0000, 1'b0, 1'b1);
      drain();
      expect_out("t5_acc_a", 17'h00005);
      expect_out("t5_acc_b", 17'h00008);
      expect_out("t5_acc_c", 17'h08002);
      expect_out("t5_acc_d", 17'h00002);
      expect_out("t5_acc_e", 17'h08004);

      // backpressure
      got_q.delete();
      cycle(1'b1, 2'b01, 16'h0001, 16'h0001, 1'b0, 1'b0);
      cycle(1'b1, 2'b01, 16'h0002, 16'h0002, 1'b0, 1'b0);
      cycle(1'b1, 2'b01, 16'h0003, 16'h0003, 1'b0, 1'b0);
      check("bp_ready", {31'd0, bus_if.SINK_READY}, 32'd0);
      check("bp_hold", {16'd0, bus_if.SOURCE_DATA}, 32'h0002);
      cycle(1'b1, 2'b01, 16'h0003, 16'h0003, 1'b0, 1'b0);
      check("bp_hold2", {16'd0, bus_if.SOURCE_DATA}, 32'h0002);
      check("bp_count", exp_q.size(), 32'd2);
      cycle(1'b1, 2'b01, 16'h0003, 16'h0003, 1'b0, 1'b1);
      drain();
      expect_out("bp_o1", 17'h00002);
      expect_out("bp_o2", 17'h00004);
      expect_out("bp_o3", 17'h00006);

      // reset mid-stream discards the buffered beats and clears ACC
      got_q.delete();
      cycle(1'b1, 2'b10, 16'h0009, 16'h0000, 1'b1, 1'b0);
      cycle(1'b1, 2'b10, 16'h0001, 16'h0000, 1'b0, 1'b0);
      cycle(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
      check("pre_rst_valid", {31'd0, bus_if.SOURCE_VALID}, 32'd1);
      #2;
      RESET_n = 1'b0;
      #1;
      check("rst_async_valid", {31'd0, bus_if.SOURCE_VALID}, 32'd0);
      check("rst_async_ready", {31'd0, bus_if.SINK_READY}, 32'd1);
      exp_q.delete();
      acc_m = 0;
      cycle(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
      @(negedge CLK);
      RESET_n = 1'b1;
      cycle(1'b1, 2'b10, 16'h0007, 16'h0000, 1'b0, 1'b1);
      drain();
      expect_out("post_rst_acc", 17'h00007);

      // randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 3) == 0) ra[W-2:0] = {(W-1){1'b1}} - (W-1)'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) rb[W-2:0] = (W-1)'($urandom_range(0, 2));
         cycle(logic'($urandom_range(0, 9) < 7), 2'($urandom), ra, rb,
               logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 9) < 7));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
